// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings for the elastic pipeline stage
package pipe_pkg;

  localparam int CNT_W = 2;

  // State value doubles as the number of entries held
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] count_of(input state_t st);
    return CNT_W'(st);
  endfunction

endpackage

// File: rtl/flopenr_n.sv
// rtl/flopenr_n.sv - data register with async reset, sync clear-to-value and enable
module flopenr_n #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over enable so a squash always lands the reset value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - elastic pipeline register with skid buffer and flush
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic [1:0]       o_count
);

  state_t           state;
  state_t           state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Next state and register enables; a flush overrides everything
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = i_d;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_en   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en   = 1'b1;
          state_nxt = ST_FULL;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        main_d = skid_q;
        if (out_fire) begin
          main_en   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (i_flush) begin
      state_nxt = ST_EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
  end

  // Control FSM with registered handshake/count outputs so i_ready never reaches o_ready
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_count <= count_of(ST_EMPTY);
    end else begin
      state   <= state_nxt;
      o_valid <= (state_nxt != ST_EMPTY);
      o_ready <= (state_nxt != ST_FULL);
      o_count <= count_of(state_nxt);
    end
  end

  flopenr_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .clr     (i_flush),
    .en      (main_en),
    .d       (main_d),
    .q       (o_q)
  );

  flopenr_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .clr     (i_flush),
    .en      (skid_en),
    .d       (i_d),
    .q       (skid_q)
  );

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
Parametrised elastic pipeline register, the next generation of the team's plain data flop. Adds:
- valid/ready handshake on both sides;
- a one-entry skid buffer, so downstream stalls do not combinationally reach upstream;
- a synchronous flush for branch/exception squash;
- a configurable reset/flush data value.

It is dropped between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of bare registers.

Parameters:
WIDTH, 32, width of the data payload in bits
RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on reset and on flush

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_reset_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous squash; empties the stage
i_valid  input  1  upstream has data on i_d
o_ready  output  1  stage can accept data this cycle (registered)
i_d  input  WIDTH  upstream payload
o_valid  output  1  o_q holds valid data
i_ready  input  1  downstream accepts o_q this cycle
o_q  output  WIDTH  payload to downstream (driven from the main register)
o_count  output  2  entries held: 0, 1 or 2

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous, active-low (i_reset_n).
- Handshake signals:
  - in_fire = i_valid & o_ready
  - out_fire = o_valid & i_ready
- Reset (i_reset_n=0, asynchronous, any cycle including mid-transfer):
  - state=EMPTY; main and skid registers = RESET_VAL;
  - o_valid=0, o_ready=1, o_count=0, o_q=RESET_VAL;
  - held for as long as i_reset_n=0; no capture while in reset.
- States:
  - EMPTY: count 0, o_valid=0, o_ready=1.
  - BUSY: count 1, o_valid=1, o_ready=1.
  - FULL: count 2, o_valid=1, o_ready=0.
- Transitions (only when flush is low):
  - EMPTY & in_fire -> main<=i_d, BUSY.
  - BUSY & in_fire & out_fire -> main<=i_d, stay BUSY (full throughput).
  - BUSY & in_fire & !out_fire -> skid<=i_d, FULL.
  - BUSY & !in_fire & out_fire -> EMPTY.
  - FULL & out_fire -> main<=skid, BUSY.
  - FULL: in_fire cannot occur because o_ready=0.
  - All other cases hold state and data.
- Flush:
  - i_flush=1 at an edge -> EMPTY; main and skid <= RESET_VAL.
  - Flush has priority over simultaneous in_fire and out_fire; data offered that cycle is dropped.
  - In the flush cycle o_valid still reflects the pre-edge state. Downstream must qualify with its own flush.
- Output timing:
  - o_ready is a registered signal: no combinational path from i_ready to o_ready.
  - o_q and o_valid are registered: latency is 1 cycle from in_fire to o_valid.
- Hold rule: while o_valid=1 and i_ready=0, o_q must not change. The skid register absorbs the in-flight beat.
- Ordering: FIFO order is preserved; the skid entry is always older than any later input.
- Bandwidth: sustained 1 beat/cycle whenever i_ready stays high.
- Data registers update only on a capture, a skid->main move, or flush/reset. No spurious toggling.

Decomposition:
- Shared package pipe_pkg holds:
  - 2-bit state encodings ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b10;
  - the o_count encoding, equal to the state value.
- Natural sub-module flopenr_n: a WIDTH-bit register with async active-low reset, synchronous clear-to-value and enable.
  - Instantiated twice: main and skid.
  - The control FSM stays in pipe_stage.

Test Plan:
- Reset mid-stream: in FULL with main=0xA, skid=0xB, drop i_reset_n between edges -> immediately o_valid=0, o_ready=1, o_count=0, o_q=RESET_VAL. After release, first accepted 0x1 appears on o_q one cycle later.
- Streaming: i_valid=1, i_ready=1, i_d=1,2,3,...,10 on consecutive cycles -> o_q=1..10 on consecutive cycles, lagging by 1. o_ready stays 1 and o_count stays 1.
- Backpressure/skid: stream 0x11,0x22,0x33; i_ready=0 from the cycle 0x11 appears.
  - Expected: o_q holds 0x11, 0x22 goes to skid, o_count=2, o_ready=0 next cycle, 0x33 not taken.
  - Then raise i_ready: outputs 0x11, 0x22, 0x33 in order; no loss and no duplicate.
- Flush priority: in BUSY, assert i_flush with i_valid=1 (i_d=0x55) and i_ready=1 -> next cycle o_valid=0, o_count=0, o_q=RESET_VAL, 0x55 never output.
- Flush from FULL: main=0x1, skid=0x2, i_flush=1 -> EMPTY, o_ready=1 next cycle, neither 0x1 nor 0x2 output afterwards.
- Random valid/ready (10k cycles, WIDTH=8 and WIDTH=64, RESET_VAL=0xDEAD...) against a scoreboard queue:
  - in-order, lossless delivery;
  - o_q stable while stalled;
  - o_ready never depends on same-cycle i_ready.
